stream_mux: RTL and testbench

//   N-channel, BUS-wide stream multiplexer with valid/ready handshake and packet locking.

---
 rtl/stream_mux_pkg.sv | 28 ++
 rtl/stream_mux_rr_arbiter.sv | 33 +++
 rtl/stream_mux.sv | 121 ++++++++++++
 tb/tb_stream_mux.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared state type and round-robin helper for stream_mux.
// Optional feature macro: STREAM_MUX_RR_EN (round-robin arbitration).
package stream_mux_pkg;

  typedef enum logic {IDLE, LOCKED} mux_state_e;

  // Upper bound on channel count the round-robin helper can search.
  localparam int RR_MAX_CH = 64;

  // First requesting index searching upward from (ptr+1) mod n.
  // Returns ptr unchanged when nothing requests.
  function automatic int next_rr(input int ptr, input logic [RR_MAX_CH-1:0] req, input int n);
    int   idx;
    logic found;
    next_rr = ptr;
    found   = 1'b0;
    for (int i = 1; i <= RR_MAX_CH; i++) begin
      if (i <= n) begin
        idx = (ptr + i) % n;
        if (!found && req[idx]) begin
          next_rr = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter: round-robin winner selection with its own last-grant pointer.
// Only instantiated when STREAM_MUX_RR_EN is defined.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [CHANNELS-1:0] i_req,
  input  logic                i_update,
  output logic [SEL_W-1:0]    o_winner,
  output logic                o_any_req
);

  logic [SEL_W-1:0]     r_ptr;
  logic [RR_MAX_CH-1:0] w_req_ext;

  assign w_req_ext = RR_MAX_CH'(i_req);
  assign o_winner  = SEL_W'(next_rr(int'(r_ptr), w_req_ext, CHANNELS));
  assign o_any_req = |i_req;

  // Last-grant pointer starts at the top channel so channel 0 wins first.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= SEL_W'(CHANNELS - 1);
    end else if (i_update) begin
      r_ptr <= o_winner;
    end
  end

endmodule

// File: rtl/stream_mux.sv
// stream_mux: N-channel stream multiplexer with packet locking and a
// registered output stage. Define STREAM_MUX_RR_EN for round-robin
// arbitration; otherwise the channel is chosen by sel while idle.
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter  int BUS      = 32,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BUS-1:0]      in_data [CHANNELS],
  input  logic [CHANNELS-1:0] in_valid,
  input  logic [CHANNELS-1:0] in_last,
  output logic [CHANNELS-1:0] in_ready,
  input  logic [SEL_W-1:0]    sel,
  output logic [BUS-1:0]      out_data,
  output logic                out_valid,
  output logic                out_last,
  input  logic                out_ready,
  output logic [SEL_W-1:0]    grant,
  output logic                busy
);

  mux_state_e       r_state, w_state_nxt;
  logic [SEL_W-1:0] r_grant, w_grant_nxt;
  logic [BUS-1:0]   r_out_data;
  logic             r_out_valid;
  logic             r_out_last;

  logic             w_arb_go;
  logic [SEL_W-1:0] w_arb_idx;
  logic             w_arb_take;
  logic             w_rdy;
  logic             w_in_hs;
  logic             w_in_last;

`ifdef STREAM_MUX_RR_EN
  // sel is kept on the port list for a common interface but plays no part here.
  logic w_unused_sel;
  assign w_unused_sel = ^sel;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_rr_arbiter (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req     (in_valid),
    .i_update  (w_arb_take),
    .o_winner  (w_arb_idx),
    .o_any_req (w_arb_go)
  );
`else
  assign w_arb_idx = sel;
  assign w_arb_go  = (32'(sel) < CHANNELS) && in_valid[sel];
`endif

  assign w_arb_take = (r_state == IDLE) && w_arb_go;

  // The granted producer may push whenever the output slot is free or draining.
  assign w_rdy     = (r_state == LOCKED) && (!r_out_valid || out_ready);
  assign w_in_hs   = w_rdy && in_valid[r_grant];
  assign w_in_last = in_last[r_grant];
  assign in_ready  = w_rdy ? (CHANNELS'(1) << r_grant) : '0;

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign grant     = r_grant;
  assign busy      = (r_state == LOCKED);

  // State and grant registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
    end
  end

  // Next state: lock onto a channel while idle, release after its last beat.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    case (r_state)
      IDLE: begin
        if (w_arb_go) begin
          w_state_nxt = LOCKED;
          w_grant_nxt = w_arb_idx;
        end
      end
      LOCKED: begin
        if (w_in_hs && w_in_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output register: load on input handshake, empty when drained with nothing new.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_in_hs) begin
      r_out_data  <= in_data[r_grant];
      r_out_last  <= w_in_last;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux.sv
module tb_stream_mux;

  localparam int BUS = 32;
  localparam int CH  = 4;
`ifdef STREAM_MUX_RR_EN
  localparam int DECOY_RAND = 0;
  localparam int DECOY_ALL  = 0;
`else
  localparam int DECOY_RAND = 1;
  localparam int DECOY_ALL  = 2;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [BUS-1:0] in_data [CH];
  logic [CH-1:0]  in_valid, in_last, in_ready;
  logic [1:0]     sel, grant;
  logic [BUS-1:0] out_data;
  logic           out_valid, out_last, out_ready, busy;

  logic [BUS-1:0] in_data2 [3];
  logic [2:0]     in_valid2, in_last2, in_ready2;
  logic [1:0]     sel2, grant2;
  logic [BUS-1:0] out_data2;
  logic           out_valid2, out_last2, out_ready2, busy2;

  stream_mux #(.BUS(BUS), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready), .grant(grant), .busy(busy)
  );

  stream_mux #(.BUS(BUS), .CHANNELS(3)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2), .in_last(in_last2),
    .in_ready(in_ready2), .sel(sel2), .out_data(out_data2), .out_valid(out_valid2),
    .out_last(out_last2), .out_ready(out_ready2), .grant(grant2), .busy(busy2)
  );

  always #5 clk = ~clk;

  int             n_tests = 0;
  int             n_fail  = 0;
  logic [BUS:0]   exp_q[$];
  bit             chk_en    = 1'b0;
  bit             ir_chk_en = 1'b1;
  int             mon_cnt   = 0;
  int             cur_ch    = 0;
  int             cons_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CH-1:0] own_mask(input int c);
    logic [CH-1:0] m;
    m = '0;
    m[c] = 1'b1;
    return m;
  endfunction

  // Scoreboard monitor: every output handshake must match the next expected beat.
  initial begin
    logic [BUS:0] e;
    forever begin
      @(negedge clk);
      if (!rst && chk_en && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(out_data), 64'hDEAD_0000_0000);
        end else begin
          e = exp_q.pop_front();
          chk("out_beat", 64'({out_last, out_data}), 64'(e));
        end
        mon_cnt++;
      end
    end
  end

  // Only the channel being driven as the current packet may ever see ready.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && ir_chk_en && in_ready != '0)
        chk("in_ready_owner", 64'(in_ready), 64'(own_mask(cur_ch)));
    end
  end

  // Consumer: always ready, random ready, or stalled.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (cons_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one packet on channel ch. decoy: 0 others idle, 1 others random, 2 others valid.
  // alt_sel >= 0 forces sel to that value after the first beat. total_wait counts
  // cycles in which the packet's producer was not accepted.
  task automatic send_pkt(input int ch, input int len, input int gap_pct, input int decoy,
                          input int alt_sel, output int total_wait);
    logic [BUS-1:0] d;
    bit             hs;
    bit             lst;
    int             waited;
    cur_ch     = ch;
    sel        = 2'(ch);
    total_wait = 0;
    for (int b = 0; b < len; b++) begin
      d   = $urandom;
      lst = (b == len - 1);
      exp_q.push_back({lst, d});
      waited = 0;
      hs     = 1'b0;
      while (!hs) begin
        for (int i = 0; i < CH; i++) begin
          if (i != ch) begin
            in_valid[i] = (decoy == 2) ? 1'b1 : (decoy == 1) ? 1'($urandom_range(1)) : 1'b0;
            in_data[i]  = $urandom;
            in_last[i]  = 1'($urandom_range(1));
          end
        end
        in_valid[ch] = ($urandom_range(99) >= gap_pct);
        in_data[ch]  = d;
        in_last[ch]  = lst;
        if (b > 0 && alt_sel >= 0) sel = 2'(alt_sel);
        else if (b > 0 && decoy == 1) sel = 2'($urandom_range(CH - 1));
        @(negedge clk);
        hs = in_valid[ch] && in_ready[ch];
        if (hs) begin
          chk("grant_at_hs", 64'(grant), 64'(ch));
          chk("busy_at_hs", 64'(busy), 64'd1);
        end
        @(posedge clk);
        #1;
        if (hs) begin
          chk("latency_beat", 64'({out_last, out_data}), 64'({lst, d}));
          chk("latency_valid", 64'(out_valid), 64'd1);
        end else begin
          waited++;
          if (waited > 200) begin
            chk("hs_timeout", 64'(waited), 64'd0);
            hs = 1'b1;
          end
        end
      end
      total_wait += waited;
    end
    in_valid = '0;
    chk("bubble_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    int           w;
    int           rr_ptr;
    int           exp_ch;
    int           last_cyc;
    int           cyc;
    bit           got;
    logic [31:0]  held;
    int           base;

    rst = 1'b1;
    in_valid = '0; in_last = '0; sel = '0;
    for (int i = 0; i < CH; i++) in_data[i] = '0;
    for (int i = 0; i < 3; i++) in_data2[i] = 32'h1000 + 32'(i);
    in_valid2 = 3'b111; in_last2 = 3'b000; sel2 = 2'd3; out_ready2 = 1'b1;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

`ifdef STREAM_MUX_RR_EN
    // All channels send one-beat packets: grants rotate 0,1,2,3,0 with one bubble each.
    ir_chk_en = 1'b0;
    rr_ptr = CH - 1;
    in_valid = '1;
    in_last  = '1;
    for (int i = 0; i < CH; i++) in_data[i] = $urandom;
    last_cyc = 0;
    cyc = 0;
    for (int k = 0; k < 5; k++) begin
      exp_ch = -1;
      for (int j = 1; j <= CH; j++)
        if (exp_ch < 0 && in_valid[(rr_ptr + j) % CH]) exp_ch = (rr_ptr + j) % CH;
      exp_q.push_back({1'b1, in_data[exp_ch]});
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        @(negedge clk);
        cyc++;
        if (in_ready != '0) begin
          got = 1'b1;
          chk("rr_grant", 64'(grant), 64'(exp_ch));
          chk("rr_ready", 64'(in_ready), 64'(own_mask(exp_ch)));
          if (k > 0) chk("rr_spacing", 64'(cyc - last_cyc), 64'd2);
          last_cyc = cyc;
        end
        @(posedge clk);
        #1;
      end
      if (!got) chk("rr_timeout", 64'd0, 64'd1);
      in_data[exp_ch] = $urandom;
      rr_ptr = exp_ch;
    end
    in_valid = '0;
    in_last  = '0;
    repeat (3) @(posedge clk);
    #1;
    ir_chk_en = 1'b1;
`else
    // Out-of-range sel on a 3-channel instance: never grants, never outputs.
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("oor_busy", 64'(busy2), 64'd0);
      chk("oor_out_valid", 64'(out_valid2), 64'd0);
      chk("oor_in_ready", 64'(in_ready2), 64'd0);
    end
    @(posedge clk);
    #1;
`endif

    // Three-beat packet on channel 2: grant after one idle cycle, beats back to back.
    cons_mode = 0;
    send_pkt(2, 3, 0, 0, -1, w);
    chk("pkt_wait_cycles", 64'(w), 64'd1);

    // Lock: sel moves to 1 while channel 1 is valid; channel 1 waits for the bubble.
    send_pkt(2, 4, 0, DECOY_ALL, 1, w);
    send_pkt(1, 2, 0, 0, -1, w);
    chk("lock_bubble_wait", 64'(w), 64'd1);

    // Backpressure mid-packet: output held and producer stalled for 4 cycles.
    base = mon_cnt;
    fork
      send_pkt(1, 6, 0, 0, -1, w);
      begin
        for (int t = 0; t < 50 && mon_cnt < base + 2; t++) @(negedge clk);
        @(negedge clk);
        cons_mode = 2;
        held = '0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("bp_out_valid", 64'(out_valid), 64'd1);
          chk("bp_in_ready", 64'(in_ready), 64'd0);
          if (k == 0) held = out_data;
          else chk("bp_data_hold", 64'(out_data), 64'(held));
        end
        cons_mode = 0;
      end
    join

    // Randomized traffic with decoys, gaps and a random consumer.
    cons_mode = 1;
    for (int p = 0; p < 40; p++)
      send_pkt($urandom_range(CH - 1), $urandom_range(5, 1), 25, DECOY_RAND, -1, w);
    cons_mode = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset mid-packet.
    chk_en = 1'b0;
    cur_ch = 0;
    sel = 2'd0;
    in_data[0] = 32'hA5A5_5A5A;
    in_last = '0;
    in_valid = 4'b0001;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    chk("arst_out_data", 64'(out_data), 64'd0);
    chk("arst_grant", 64'(grant), 64'd0);
    in_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
